// File: rtl/game_tick_sequencer.sv
// Turns edges of the slow divided game tick into step-request handshakes.
// Ticks that arrive while a step is outstanding are queued up to MAX_PENDING.
package snake_pkg;
  typedef enum logic [1:0] {MENU, GAME, PAUSED, GAME_OVER} game_mode;
endpackage

module game_tick_sequencer
  import snake_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int BOTH_EDGES    = 1,
  parameter int MAX_PENDING   = 3,
  parameter int STEP_CNT_BITS = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  game_mode                 mode,
  input  logic                     tick_level,
  input  logic                     step_ack,
  output logic                     step_req,
  output logic [3:0]               pending,
  output logic                     overrun,
  output logic [STEP_CNT_BITS-1:0] step_count,
  output logic                     tick_seen
);

  typedef enum logic {IDLE, REQ} state_t;

  logic [SYNC_STAGES-1:0]   sync_q, sync_d;
  logic                     hist_q, hist_d;
  logic                     tick_seen_q, tick_seen_d;
  state_t                   state_q, state_d;
  logic                     step_req_q, step_req_d;
  logic [3:0]               pending_q, pending_d;
  logic                     overrun_q, overrun_d;
  logic [STEP_CNT_BITS-1:0] step_count_q, step_count_d;

  logic game_active;
  logic edge_det;
  logic tick;
  logic ack;

  // Handshake: step_req stays high until a cycle with step_ack high;
  // that cycle completes the step. step_ack while step_req is low is ignored.
  always_comb begin
    sync_d[0] = tick_level;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    hist_d = sync_q[SYNC_STAGES-1];

    game_active = (mode == GAME);
    if (BOTH_EDGES != 0) edge_det = sync_q[SYNC_STAGES-1] ^ hist_q;
    else                 edge_det = sync_q[SYNC_STAGES-1] & ~hist_q;
    tick_seen_d = game_active & edge_det;

    // The FSM consumes the registered tick, so a request follows tick_seen by one cycle.
    tick = game_active & tick_seen_q;
    ack  = step_req_q & step_ack;

    state_d      = state_q;
    step_req_d   = step_req_q;
    pending_d    = pending_q;
    overrun_d    = overrun_q;
    step_count_d = step_count_q;

    if (!game_active) begin
      state_d    = IDLE;
      step_req_d = 1'b0;
      pending_d  = 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pending_q != 4'd0) begin
            state_d    = REQ;
            step_req_d = 1'b1;
            if (!tick) pending_d = pending_q - 4'd1;
          end else if (tick) begin
            state_d    = REQ;
            step_req_d = 1'b1;
          end
        end
        REQ: begin
          if (ack) begin
            step_count_d = step_count_q + STEP_CNT_BITS'(1);
            step_req_d   = 1'b0;
            if (tick) begin
              state_d = REQ;
            end else if (pending_q != 4'd0) begin
              pending_d = pending_q - 4'd1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            // Low step_req in REQ is the one-cycle gap between back-to-back steps.
            if (!step_req_q) step_req_d = 1'b1;
            if (tick) begin
              if (pending_q == 4'(MAX_PENDING)) overrun_d = 1'b1;
              else                              pending_d = pending_q + 4'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q       <= '0;
      hist_q       <= 1'b0;
      tick_seen_q  <= 1'b0;
      state_q      <= IDLE;
      step_req_q   <= 1'b0;
      pending_q    <= 4'd0;
      overrun_q    <= 1'b0;
      step_count_q <= '0;
    end else begin
      sync_q       <= sync_d;
      hist_q       <= hist_d;
      tick_seen_q  <= tick_seen_d;
      state_q      <= state_d;
      step_req_q   <= step_req_d;
      pending_q    <= pending_d;
      overrun_q    <= overrun_d;
      step_count_q <= step_count_d;
    end
  end

  assign step_req   = step_req_q;
  assign pending    = pending_q;
  assign overrun    = overrun_q;
  assign step_count = step_count_q;
  assign tick_seen  = tick_seen_q;

endmodule

// File: tb/tb_game_tick_sequencer.sv
// Directed bench for game_tick_sequencer: stimulus pushes expected step counts,
// a monitor pops them on each completed handshake.
module tb_game_tick_sequencer;
  import snake_pkg::*;

  logic        clk;
  logic        rst_n;
  game_mode    mode;
  logic        tick_level;
  logic        step_ack;
  logic        step_req;
  logic [3:0]  pending;
  logic        overrun;
  logic [15:0] step_count;
  logic        tick_seen;

  logic [15:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  game_tick_sequencer #(
    .SYNC_STAGES(2), .BOTH_EDGES(1), .MAX_PENDING(3), .STEP_CNT_BITS(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .tick_level(tick_level),
    .step_ack(step_ack), .step_req(step_req), .pending(pending),
    .overrun(overrun), .step_count(step_count), .tick_seen(tick_seen)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick_level = 1'b0;
    step_ack   = 1'b0;
    mode       = GAME;
    rst_n      = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic toggle(input int wait_cycles);
    tick_level = ~tick_level;
    repeat (wait_cycles) step();
  endtask

  task automatic wait_req();
    for (int i = 0; i < 20 && step_req !== 1'b1; i++) step();
    check("req_timeout", step_req, 1);
  endtask

  task automatic ack_once(input logic [15:0] exp_cnt);
    wait_req();
    exp_q.push_back(exp_cnt);
    step_ack = 1'b1;
    step();
    step_ack = 1'b0;
  endtask

  // Scoreboard monitor
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && step_req === 1'b1 && step_ack === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_handshake", 1, 0);
        end else begin
          e = exp_q.pop_front();
          @(negedge clk);
          check("sb_step_count", step_count, e);
        end
      end
    end
  end

  initial begin
    int hits;
    do_reset();
    check("rst_step_req", step_req, 0);
    check("rst_pending", pending, 0);
    check("rst_overrun", overrun, 0);
    check("rst_step_count", step_count, 0);
    check("rst_tick_seen", tick_seen, 0);

    // Latency: edge at T, tick_seen at T+3, step_req at T+4, ack at T+10
    toggle(3);
    check("lat_tick_seen", tick_seen, 1);
    check("lat_req_early", step_req, 0);
    step();
    check("lat_step_req", step_req, 1);
    check("lat_tick_seen_pulse", tick_seen, 0);
    repeat (6) step();
    exp_q.push_back(16'd1);
    step_ack = 1'b1;
    step();
    step_ack = 1'b0;
    check("t1_req_dropped", step_req, 0);
    check("t1_count", step_count, 1);
    repeat (3) step();
    check("t1_idle", step_req, 0);

    // Ten toggles, ack two cycles after each request
    do_reset();
    for (int k = 0; k < 10; k++) begin
      tick_level = ~tick_level;
      wait_req();
      repeat (2) step();
      ack_once(16'(k + 1));
      check("t2_pending", pending, 0);
      step();
    end
    check("t2_count", step_count, 10);
    check("t2_overrun", overrun, 0);

    // Fill the queue, overrun on the fifth tick, then drain
    do_reset();
    for (int k = 0; k < 4; k++) toggle(8);
    check("t3_pending_full", pending, 3);
    check("t3_no_overrun_yet", overrun, 0);
    toggle(8);
    check("t3_pending_capped", pending, 3);
    check("t3_overrun", overrun, 1);
    for (int k = 0; k < 4; k++) begin
      ack_once(16'(k + 1));
      check("t3_gap_low", step_req, 0);
      check("t3_pending_drain", pending, (k < 3) ? 2 - k : 0);
      step();
      check("t3_next_req", step_req, (k < 3) ? 1 : 0);
    end
    check("t3_overrun_sticky", overrun, 1);

    // Tick coincides with ack in REQ
    do_reset();
    toggle(0);
    wait_req();
    toggle(3);
    check("t4_tick_seen", tick_seen, 1);
    exp_q.push_back(16'd1);
    step_ack = 1'b1;
    step();
    step_ack = 1'b0;
    check("t4_gap_low", step_req, 0);
    check("t4_pending", pending, 0);
    step();
    check("t4_req_again", step_req, 1);
    ack_once(16'd2);
    step();
    check("t4_idle", step_req, 0);

    // Leave GAME with two ticks queued while tick_level keeps moving
    do_reset();
    for (int k = 0; k < 3; k++) toggle(8);
    check("t5_pending_before", pending, 2);
    mode = MENU;
    step();
    check("t5_pending_cleared", pending, 0);
    check("t5_req_cleared", step_req, 0);
    for (int i = 1; i < 20; i++) begin
      if (i == 2 || i == 9 || i == 14) tick_level = ~tick_level;
      step();
    end
    mode = GAME;
    hits = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (step_req !== 1'b0 || tick_seen !== 1'b0) hits++;
    end
    check("t5_no_spurious", hits, 0);
    check("t5_pending_after", pending, 0);
    tick_level = ~tick_level;
    ack_once(16'd1);
    check("t5_count", step_count, 1);

    // Reset in the middle of a handshake with step_count = 7
    do_reset();
    for (int k = 0; k < 7; k++) begin
      tick_level = ~tick_level;
      ack_once(16'(k + 1));
      repeat (4) step();
    end
    check("t6_count_before", step_count, 7);
    tick_level = ~tick_level;
    wait_req();
    rst_n = 1'b0;
    step();
    check("t6_rst_req", step_req, 0);
    check("t6_rst_count", step_count, 0);
    check("t6_rst_pending", pending, 0);
    check("t6_rst_overrun", overrun, 0);
    check("t6_rst_tick_seen", tick_seen, 0);
    rst_n = 1'b1;
    step_ack = 1'b1;
    step();
    step_ack = 1'b0;
    step();
    check("t6_ack_ignored", step_count, 0);
    check("t6_no_req", step_req, 0);

    repeat (3) step();
    check("sb_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
